// File: rtl/bmem_responder_pkg.sv
//------------------------------------------------------------------------------
// Module   : bmem_responder_pkg
// Purpose  : Shared types and constants for the burst-memory responder.
//            Beat/line geometry, the queued read request record, the return
//            FSM state encoding and a line-alignment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bmem_responder_pkg;

   localparam int BMEM_BEATS  = 4;
   localparam int BMEM_BEAT_W = 64;
   localparam int BMEM_LINE_W = 256;

   // One accepted read: line-aligned address plus the cycle it was accepted.
   typedef struct packed {
      logic [31:0] addr;
      logic [15:0] stamp;
   } bmem_req_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_BEAT0 = 3'd2,
      ST_BEAT1 = 3'd3,
      ST_BEAT2 = 3'd4,
      ST_BEAT3 = 3'd5
   } bmem_state_e;

   function automatic logic [31:0] line_align(input logic [31:0] a);
      return {a[31:5], 5'b0};
   endfunction

endpackage

`default_nettype wire

// File: rtl/bmem_req_fifo.sv
//------------------------------------------------------------------------------
// Module   : bmem_req_fifo
// Purpose  : Small FIFO of outstanding read requests. Exposes both the head
//            entry and the entry behind it so the return FSM can chain bursts
//            without an idle cycle.
// Ports    : clk, rst (sync, active-low)
//            i_push/i_data  - enqueue request
//            i_pop          - dequeue head
//            o_head/o_next  - entry at head and head+1
//            o_full/o_empty/o_count - occupancy
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bmem_req_fifo
   import bmem_responder_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  bmem_req_t              i_data,
   input  logic                   i_pop,
   output bmem_req_t              o_head,
   output bmem_req_t              o_next,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

   bmem_req_t      r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [AW:0]    r_count;
   logic [AW-1:0]  w_rd_nxt;
   logic           w_push;
   logic           w_pop;

   assign w_rd_nxt = r_rd_ptr + AW'(1);
   assign w_push   = i_push & ~o_full;
   assign w_pop    = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_nxt;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_next  = r_mem[w_rd_nxt];
   assign o_full  = (r_count == c_full);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/bmem_responder.sv
//------------------------------------------------------------------------------
// Module   : bmem_responder
// Purpose  : Burst-memory responder. Accepts single-cycle line reads and
//            4-beat line write bursts; returns each read as 4 in-order 64-bit
//            beats a fixed latency after acceptance.
// Ports    : clk, rst (sync, active-low)
//            bmem_addr/bmem_read/bmem_write/bmem_wdata - request side
//            bmem_ready                                 - request accepted
//            bmem_raddr/bmem_rdata/bmem_rvalid          - read beat return
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bmem_responder
   import bmem_responder_pkg::*;
#(
   parameter int MEM_LINES = 1024,
   parameter int LATENCY   = 4,
   parameter int DEPTH     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bmem_addr,
   input  logic        bmem_read,
   input  logic        bmem_write,
   input  logic [63:0] bmem_wdata,
   output logic        bmem_ready,
   output logic [31:0] bmem_raddr,
   output logic [63:0] bmem_rdata,
   output logic        bmem_rvalid
);

   localparam int IDXW = $clog2(MEM_LINES);
   localparam int CW   = $clog2(DEPTH) + 1;
   // The launch decision is made one cycle before beat 0 appears.
   localparam logic [15:0]   c_due   = 16'(LATENCY - 1);
   localparam logic [CW-1:0] c_depth = CW'(DEPTH);
   localparam logic [1:0]    c_last  = 2'(BMEM_BEATS - 1);

   logic [BMEM_LINE_W-1:0] r_mem [MEM_LINES];

   bmem_state_e            r_state;
   logic [15:0]            r_time;
   logic                   r_rdy;
   logic                   r_wbusy;
   logic [1:0]             r_wcnt;
   logic [BMEM_LINE_W-1:0] r_wbuf;
   logic [IDXW-1:0]        r_widx;
   logic [BMEM_LINE_W-1:0] r_line;
   logic                   r_rvalid;
   logic [31:0]            r_raddr;
   logic [BMEM_BEAT_W-1:0] r_rdata;

   logic                   w_rd_acc;
   logic                   w_wr_first;
   logic                   w_wr_beat;
   logic                   w_commit;
   logic                   w_pop;
   logic                   w_full;
   logic                   w_empty;
   logic [CW-1:0]          w_count;
   logic [CW-1:0]          w_count_nxt;
   logic                   w_wbusy_nxt;
   bmem_req_t              w_push_req;
   bmem_req_t              w_head;
   bmem_req_t              w_next;
   bmem_req_t              w_sel;
   logic                   w_head_due;
   logic                   w_next_due;
   logic                   w_more;
   logic                   w_launch;
   logic [BMEM_LINE_W-1:0] w_sel_line;
   logic                   w_unused_addr;

   assign w_unused_addr = ^bmem_addr[4:0];

   // Ready is registered; only the reset input gates it combinationally.
   assign bmem_ready = rst & r_rdy;

   assign w_rd_acc   = bmem_read & bmem_ready & ~bmem_write & ~r_wbusy;
   assign w_wr_first = bmem_write & bmem_ready & ~r_wbusy;
   assign w_wr_beat  = r_wbusy & bmem_write;
   assign w_commit   = rst & w_wr_beat & (r_wcnt == c_last);
   assign w_pop      = (r_state == ST_BEAT3);
   assign w_push_req = '{addr: line_align(bmem_addr), stamp: r_time};

   bmem_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_rd_acc),
      .i_data  (w_push_req),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_next  (w_next),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Modular difference keeps the comparison valid across timestamp wrap.
   assign w_head_due = (16'(r_time - w_head.stamp) >= c_due);
   assign w_next_due = (16'(r_time - w_next.stamp) >= c_due);
   assign w_more     = (w_count > CW'(1));

   // In BEAT3 the head is being popped, so the candidate is the entry behind it.
   always_comb begin
      w_launch = 1'b0;
      w_sel    = w_head;
      case (r_state)
         ST_IDLE, ST_WAIT: w_launch = ~w_empty & w_head_due;
         ST_BEAT3: begin
            w_launch = w_more & w_next_due;
            w_sel    = w_next;
         end
         default: w_launch = 1'b0;
      endcase
   end

   assign w_sel_line  = r_mem[w_sel.addr[5 +: IDXW]];
   assign w_count_nxt = w_count + CW'(w_rd_acc) - CW'(w_pop);
   assign w_wbusy_nxt = r_wbusy ? (bmem_write & (r_wcnt != c_last)) : w_wr_first;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_time <= '0;
         r_rdy  <= 1'b1;
      end else begin
         r_time <= r_time + 16'd1;
         r_rdy  <= (w_count_nxt < c_depth) & ~w_wbusy_nxt;
      end
   end

   // Write beats shift in from the top so beat 0 ends up in bits [63:0].
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wbusy <= 1'b0;
         r_wcnt  <= '0;
      end else if (w_wr_first) begin
         r_wbusy <= 1'b1;
         r_wcnt  <= 2'd1;
         r_widx  <= bmem_addr[5 +: IDXW];
         r_wbuf  <= {bmem_wdata, r_wbuf[BMEM_LINE_W-1:BMEM_BEAT_W]};
      end else if (w_wr_beat) begin
         r_wcnt  <= r_wcnt + 2'd1;
         r_wbuf  <= {bmem_wdata, r_wbuf[BMEM_LINE_W-1:BMEM_BEAT_W]};
         if (r_wcnt == c_last) begin
            r_wbusy <= 1'b0;
         end
      end else if (r_wbusy) begin
         // A gap mid-burst discards the partial line.
         r_wbusy <= 1'b0;
         r_wcnt  <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_commit) begin
         r_mem[r_widx] <= {bmem_wdata, r_wbuf[BMEM_LINE_W-1:BMEM_BEAT_W]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_rvalid <= 1'b0;
         r_raddr  <= '0;
         r_rdata  <= '0;
      end else if (w_launch) begin
         r_state  <= ST_BEAT0;
         r_rvalid <= 1'b1;
         r_raddr  <= w_sel.addr;
         r_line   <= w_sel_line;
         r_rdata  <= w_sel_line[0 +: BMEM_BEAT_W];
      end else begin
         case (r_state)
            ST_IDLE, ST_WAIT: r_state <= w_empty ? ST_IDLE : ST_WAIT;
            ST_BEAT0: begin
               r_state <= ST_BEAT1;
               r_rdata <= r_line[BMEM_BEAT_W*1 +: BMEM_BEAT_W];
            end
            ST_BEAT1: begin
               r_state <= ST_BEAT2;
               r_rdata <= r_line[BMEM_BEAT_W*2 +: BMEM_BEAT_W];
            end
            ST_BEAT2: begin
               r_state <= ST_BEAT3;
               r_rdata <= r_line[BMEM_BEAT_W*3 +: BMEM_BEAT_W];
            end
            ST_BEAT3: begin
               r_state  <= (w_more | w_rd_acc) ? ST_WAIT : ST_IDLE;
               r_rvalid <= 1'b0;
               r_raddr  <= '0;
               r_rdata  <= '0;
            end
            default: begin
               r_state  <= ST_IDLE;
               r_rvalid <= 1'b0;
               r_raddr  <= '0;
               r_rdata  <= '0;
            end
         endcase
      end
   end

   assign bmem_rvalid = r_rvalid;
   assign bmem_raddr  = r_raddr;
   assign bmem_rdata  = r_rdata;

endmodule

`default_nettype wire
